mult: RTL and testbench

MULT -- requirements
Module: mult

---
 rtl/mult.sv | 162 ++++++++++++++++
 tb/tb_mult.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mult.sv
// ----------------------------------------------------------------------------
// mult -- sequential radix-2 Booth multiplier (MULT / MULTU)
//
// Captures two WIDTH-bit operands on a start request taken in IDLE. It then
// runs WIDTH+1 Booth steps on (WIDTH+1)-bit extended operands and writes the
// low 2*WIDTH bits of the exact product to hi/lo. This write happens on the
// edge that leaves RUN, and mult_end pulses for one cycle afterwards.
//
// Ports
//   clk          : clock, all state updates on rising edge
//   rst          : asynchronous active-high reset
//   mult_start   : start request, sampled only in IDLE
//   is_signed    : 1 = two's complement operands, 0 = unsigned
//   multiplicand : operand A (WIDTH bits)
//   multiplier   : operand B (WIDTH bits)
//   busy         : high while the Booth iteration is running
//   mult_end     : one-cycle completion pulse
//   hi, lo       : upper / lower halves of the last completed product
// ----------------------------------------------------------------------------
module mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             mult_end,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             busy_r;
    logic             end_r;

    // A is one bit wider than the extended operand so add/subtract never wraps.
    logic [WIDTH+1:0] a_r;
    logic [WIDTH+1:0] m_r;
    logic [WIDTH:0]   q_r;
    logic             qm1_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             last_s;
    logic [WIDTH+1:0] sum_s;
    logic [WIDTH+1:0] a_next_s;
    logic [WIDTH:0]   q_next_s;

    assign busy     = busy_r;
    assign mult_end = end_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

    // The step being executed is the last one when WIDTH steps are already done.
    assign last_s = (cnt_r == CW'(WIDTH));

    // Next-state decode for the IDLE/RUN/DONE controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (mult_start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register; busy/mult_end are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            end_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == RUN);
            end_r   <= (state_next_s == DONE);
        end
    end

    // One Booth step: add/subtract M per {Q[0], q_-1}, then arithmetic shift right.
    always_comb begin
        sum_s = a_r;
        case ({q_r[0], qm1_r})
            2'b01:   sum_s = a_r + m_r;
            2'b10:   sum_s = a_r - m_r;
            default: sum_s = a_r;
        endcase
        a_next_s = {sum_s[WIDTH+1], sum_s[WIDTH+1:1]};
        q_next_s = {sum_s[0], q_r[WIDTH:1]};
    end

    // Datapath: operand capture in IDLE, Booth iteration in RUN, result write on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= {(WIDTH+2){1'b0}};
            m_r   <= {(WIDTH+2){1'b0}};
            q_r   <= {(WIDTH+1){1'b0}};
            qm1_r <= 1'b0;
            cnt_r <= {CW{1'b0}};
            hi_r  <= {WIDTH{1'b0}};
            lo_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (mult_start) begin
                        a_r   <= {(WIDTH+2){1'b0}};
                        qm1_r <= 1'b0;
                        cnt_r <= {CW{1'b0}};
                        if (is_signed) begin
                            m_r <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                            q_r <= {multiplier[WIDTH-1], multiplier};
                        end else begin
                            m_r <= {2'b00, multiplicand};
                            q_r <= {1'b0, multiplier};
                        end
                    end
                end
                RUN: begin
                    a_r   <= a_next_s;
                    q_r   <= q_next_s;
                    qm1_r <= q_r[0];
                    cnt_r <= cnt_r + CW'(1);
                    if (last_s) begin
                        // {a_next, q_next} is the sign-extended product; q_next holds bits [WIDTH:0].
                        hi_r <= {a_next_s[WIDTH-2:0], q_next_s[WIDTH]};
                        lo_r <= q_next_s[WIDTH-1:0];
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult.sv
module tb_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic        mult_start;
    logic        is_signed;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        mult_end;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          end_cyc  = 0;
    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    mult #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mult_start   (mult_start),
        .is_signed    (is_signed),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .mult_end     (mult_end),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit integer multiplication of the interpreted operands.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint pa;
        longint pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({32'd0, a});
            pb = longint'({32'd0, b});
        end
        return 64'(pa * pb);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    // Launch one operation, watch it for a bounded number of cycles and check the result.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit disturb);
        logic [63:0] p;
        int n;
        p            = ref_prod(a, b, s);
        multiplicand = a;
        multiplier   = b;
        is_signed    = s;
        mult_start   = 1'b1;
        @(posedge clk); #1;
        mult_start = 1'b0;
        check("busy_start", 64'(busy), 64'd1);
        n = 0;
        while (mult_end !== 1'b1 && n < 40) begin
            check("hold_hi", 64'(hi), 64'(prev_hi));
            check("hold_lo", 64'(lo), 64'(prev_lo));
            if (disturb) begin
                multiplicand = 32'($urandom);
                multiplier   = 32'($urandom);
                is_signed    = 1'($urandom);
                mult_start   = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        mult_start = 1'b0;
        end_cyc    = cyc;
        check("latency", 64'(n), 64'd33);
        check("hi", 64'(hi), 64'(p[63:32]));
        check("lo", 64'(lo), 64'(p[31:0]));
        check("busy_done", 64'(busy), 64'd0);
        prev_hi = p[63:32];
        prev_lo = p[31:0];
        @(posedge clk); #1;
        check("end_pulse", 64'(mult_end), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int first_end;
        int seen;
        rst          = 1'b1;
        mult_start   = 1'b0;
        is_signed    = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        prev_hi      = 32'd0;
        prev_lo      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_end", 64'(mult_end), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        // Directed corner products
        do_op(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        do_op(32'd0, 32'h1234_5678, 1'b1, 1'b0);

        // Operand changes and start pulses during RUN must not matter
        do_op(32'd5, 32'd6, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_second_op", 64'(busy), 64'd0);
        end

        // Abort at edge 10 of an operation
        multiplicand = 32'd9;
        multiplier   = 32'd11;
        is_signed    = 1'b0;
        mult_start   = 1'b1;
        @(posedge clk); #1;
        mult_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_end", 64'(mult_end), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mult_end === 1'b1 || busy === 1'b1) seen++;
        end
        check("abort_quiet", 64'(seen), 64'd0);

        // Start held during reset is ignored, then taken on the first edge after release
        mult_start = 1'b1;
        rst        = 1'b1;
        @(posedge clk); #1;
        check("rst_ignores_start", 64'(busy), 64'd0);
        rst = 1'b0;
        do_op(32'd2, 32'd3, 1'b0, 1'b0);

        // Back-to-back with one idle cycle
        do_op(32'd1, 32'd1, 1'b1, 1'b0);
        first_end = end_cyc;
        do_op(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0);
        check("b2b_gap", 64'(end_cyc - first_end), 64'd35);

        // Randomized operands and signedness
        for (int i = 0; i < 20; i++) begin
            do_op(pick_operand(), pick_operand(), 1'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
